hilo_muldiv: RTL
================

Name: hilo_muldiv

Overview:
- Iterative multiply/divide unit with the architectural HI/LO registers, in the EX stage next to the ALU.
- Consumes R-type MULT/MULTU/DIV/DIVU/MTHI/MTLO issued by the decode/control stage; its hi/lo outputs feed the MFHI/MFLO path.
- Asserts busy so the hazard logic stalls the pipeline, and any MFHI/MFLO, until the result is written.

Parameters:
- WIDTH, 32, operand and HI/LO width; the only supported value is 32.
- DIV0_Q, 32'hFFFFFFFF, value written to LO on divide-by-zero.

Ports:
- clk  input  1  pipeline clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request valid this cycle; func is decoded only when start=1.
- func  input  6  R-type func field: 011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU, 010001 MTHI, 010011 MTLO.
- a  input  32  rs value: multiplicand, dividend, or MTHI/MTLO data.
- b  input  32  rt value: multiplier or divisor.
- flush  input  1  abort the in-flight operation (branch or exception flush).
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse; HI/LO hold the new result during this cycle.
- hi  output  32  HI register.
- lo  output  32  LO register.

Behaviour:
- Reset (rst=1 at an edge): hi=0, lo=0, busy=0, done=0, state=IDLE, counter=0. Reset overrides every other input, including mid-operation.
- States: IDLE, CALC, FIX.
- IDLE, start=1, func MULT/MULTU/DIV/DIVU, at edge E0:
  - latch magnitudes of a and b (absolute value for signed ops, raw for unsigned);
  - latch sign info;
  - counter<=0, state<=CALC, busy<=1.
- IDLE, start=1, func MTHI: hi<=a at the edge. MTLO: lo<=a. No busy, no done.
- IDLE, start=1, any other func: ignored.
- start while busy=1: ignored, no error flag. Upstream must stall and hold the request until busy=0.
- CALC: one iteration per cycle for 32 cycles (E1..E32); counter increments 0..31; at E32, with counter=31, state<=FIX.
  - Multiply: radix-2 shift-add on magnitudes into a 64-bit product.
  - Divide: restoring, 1 quotient bit per cycle; 64-bit remainder/quotient shift register; 33-bit trial subtract.
- FIX (edge E33):
  - MULT: negate the 64-bit product if sign(a)^sign(b); then hi<=product[63:32], lo<=product[31:0].
  - DIV: quotient negated if sign(a)^sign(b); remainder takes the sign of a. lo<=quotient, hi<=remainder.
  - state<=IDLE, busy<=0, done<=1.
- Timing:
  - busy=1 for exactly the 33 cycles following E0.
  - done=1 for the single cycle after E33; it clears at the next edge.
  - A new start is accepted in the cycle where done=1.
- Divide by zero (b==0, both signed and unsigned): lo<=DIV0_Q, hi<=a unmodified. Latency stays 33 cycles.
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- flush=1 at an edge:
  - state<=IDLE, busy<=0, done<=0; hi/lo keep their pre-operation values.
  - flush has priority over a same-cycle start, and that start is dropped.
  - flush during a done cycle does not undo the completed write.
- hi/lo change only at E33 of a completed op, on an MTHI/MTLO edge, or on reset.

Test Plan:
- rst, then MULTU a=FFFFFFFF b=FFFFFFFF -> busy 33 cycles; done pulse; hi=FFFFFFFE, lo=00000001.
- MULT a=FFFFFFFD (-3) b=00000005 -> hi=FFFFFFFF, lo=FFFFFFF1; same op as MULTU -> hi=00000004, lo=FFFFFFF1.
- DIV a=FFFFFFF9 (-7) b=00000002 -> lo=FFFFFFFD, hi=FFFFFFFF.
- DIVU a=00000064 b=00000007 -> lo=0000000E, hi=00000002.
- DIVU a=12345678 b=0 -> lo=FFFFFFFF, hi=12345678 at cycle 33.
- MTHI a=AAAA5555 -> hi=AAAA5555 next cycle, busy=0.
- Then start MULT, re-assert start(MTLO) at cycle 5 -> MTLO ignored; lo is the product.
- MULT in flight, flush at cycle 10 -> busy=0 next cycle, no done, hi/lo unchanged.
- DIV in flight, rst at cycle 20 -> hi=lo=0, busy=0.
- DIV 80000000 / FFFFFFFF -> lo=80000000, hi=00000000.

Source files
------------

// File: rtl/hilo_muldiv.sv
// Iterative HI/LO multiply/divide unit for the EX stage.
// Handles MULT/MULTU (shift-add) and DIV/DIVU (restoring), each taking 32 iterations plus a sign-fix cycle.
module hilo_muldiv #(
    parameter int          WIDTH  = 32,
    parameter logic [31:0] DIV0_Q = 32'hFFFFFFFF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [5:0]       func,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MTLO  = 6'b010011;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t               state;
    logic [4:0]           counter;
    logic                 isDiv;
    logic                 negRes;
    logic                 negRem;
    logic                 divZero;
    logic [WIDTH-1:0]     operand;
    logic [WIDTH-1:0]     aRaw;
    logic [2*WIDTH-1:0]   acc;

    logic                 sgnOp;
    logic [WIDTH-1:0]     magA;
    logic [WIDTH-1:0]     magB;
    logic [WIDTH:0]       mulSum;
    logic [WIDTH:0]       trial;
    logic [2*WIDTH-1:0]   mulNext;
    logic [2*WIDTH-1:0]   divNext;
    logic [2*WIDTH-1:0]   prodFix;
    logic [WIDTH-1:0]     quoFix;
    logic [WIDTH-1:0]     remFix;

    // Operand magnitudes, one iteration of each algorithm, and the final sign correction.
    // For multiply, operand holds |a| as the addend; for divide it holds |b| as the divisor.
    always_comb begin
        sgnOp   = (func == F_MULT) || (func == F_DIV);
        magA    = (sgnOp && a[WIDTH-1]) ? -a : a;
        magB    = (sgnOp && b[WIDTH-1]) ? -b : b;
        mulSum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
        mulNext = {mulSum, acc[WIDTH-1:1]};
        trial   = acc[2*WIDTH-1:WIDTH-1] - {1'b0, operand};
        divNext = trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                               : {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        prodFix = negRes ? -acc : acc;
        quoFix  = negRes ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        remFix  = negRem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    // Control FSM and HI/LO state; flush drops any same-cycle start and leaves HI/LO untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            counter <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            isDiv   <= 1'b0;
            negRes  <= 1'b0;
            negRem  <= 1'b0;
            divZero <= 1'b0;
            operand <= '0;
            aRaw    <= '0;
            acc     <= '0;
        end else if (flush) begin
            state   <= IDLE;
            counter <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        case (func)
                            F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                                isDiv   <= (func == F_DIV) || (func == F_DIVU);
                                negRes  <= sgnOp && (a[WIDTH-1] ^ b[WIDTH-1]);
                                negRem  <= sgnOp && a[WIDTH-1];
                                divZero <= (b == '0);
                                aRaw    <= a;
                                if ((func == F_DIV) || (func == F_DIVU)) begin
                                    operand <= magB;
                                    acc     <= {{WIDTH{1'b0}}, magA};
                                end else begin
                                    operand <= magA;
                                    acc     <= {{WIDTH{1'b0}}, magB};
                                end
                                counter <= '0;
                                busy    <= 1'b1;
                                state   <= CALC;
                            end
                            F_MTHI: hi <= a;
                            F_MTLO: lo <= a;
                            default: ;
                        endcase
                    end
                end
                CALC: begin
                    acc <= isDiv ? divNext : mulNext;
                    if (counter == 5'(WIDTH-1)) begin
                        counter <= '0;
                        state   <= FIX;
                    end else begin
                        counter <= counter + 5'd1;
                    end
                end
                FIX: begin
                    if (!isDiv) begin
                        hi <= prodFix[2*WIDTH-1:WIDTH];
                        lo <= prodFix[WIDTH-1:0];
                    end else if (divZero) begin
                        hi <= aRaw;
                        lo <= DIV0_Q;
                    end else begin
                        hi <= remFix;
                        lo <= quoFix;
                    end
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
